// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs compact instruction requests into MIPS words and streams them into imem
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_code,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(BASE_ADDR + DEPTH - 1);
  localparam logic [31:0]       STOP_WORD = 32'hFC00_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TERM, S_DONE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              overflow;
  logic              term_req;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  // Mnemonic code -> MIPS word; shift-immediate forms force rs to zero.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_code)
      5'd0:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h20);
      5'd1:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h21);
      5'd2:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h22);
      5'd3:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h23);
      5'd4:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
      5'd5:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
      5'd6:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h26);
      5'd7:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
      5'd8:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
      5'd9:    enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
      5'd10:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h02);
      5'd11:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h03);
      5'd12:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h04);
      5'd13:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h06);
      5'd14:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h07);
      5'd15:   enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      5'd16:   enc_word = {6'h08, in_rs, in_rt, in_imm};
      5'd17:   enc_word = {6'h09, in_rs, in_rt, in_imm};
      5'd18:   enc_word = {6'h0C, in_rs, in_rt, in_imm};
      5'd19:   enc_word = {6'h0D, in_rs, in_rt, in_imm};
      5'd20:   enc_word = {6'h0E, in_rs, in_rt, in_imm};
      5'd21:   enc_word = {6'h23, in_rs, in_rt, in_imm};
      5'd22:   enc_word = {6'h2B, in_rs, in_rt, in_imm};
      5'd23:   enc_word = {6'h04, in_rs, in_rt, in_imm};
      5'd24:   enc_word = {6'h05, in_rs, in_rt, in_imm};
      5'd25:   enc_word = {6'h02, in_target};
      5'd26:   enc_word = {6'h03, in_target};
      5'd27:   enc_word = STOP_WORD;
      default: enc_legal = 1'b0;
    endcase
  end

  assign in_ready = (state == S_RUN) & ~start;
  assign busy     = (state == S_RUN) | (state == S_TERM);
  assign accept   = in_valid & in_ready;
  assign ptr_inc  = ptr + 1'b1;
  // The slot before LAST is the final data slot; STOP always gets LAST at worst.
  assign overflow = accept & enc_legal & ~in_last & (ptr_inc == LAST);
  assign term_req = accept & in_last | overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (term_req) state_d = S_TERM;
        S_TERM:  state_d = S_DONE;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= BASE;
      count      <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        ptr       <= BASE;
        count     <= '0;
        err       <= 1'b0;
        done      <= 1'b0;
        imem_addr <= BASE;
      end else begin
        case (state)
          S_RUN: if (accept) begin
            if (enc_legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              ptr        <= ptr_inc;
              count      <= count + 1'b1;
            end
            if (!enc_legal || overflow) err <= 1'b1;
          end
          S_TERM: begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= STOP_WORD;
            ptr        <= ptr_inc;
            count      <= count + 1'b1;
          end
          S_DONE:  done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;
  localparam int AW = 5, BASE = 2, DEPTH = 8, LAST = BASE + DEPTH - 1;
  localparam logic [31:0] STOP = 32'hFC00_0000;

  logic clk, rst_n, start, in_valid, in_ready, in_last;
  logic [4:0] in_code, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic imem_we, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] count;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .count(count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [31:0] data; int at; } wr_t;
  typedef struct { logic [4:0] code, rs, rt, rd, sh; logic [15:0] imm; logic [25:0] tgt; bit last; } req_t;

  wr_t exp_q[$];
  int tests = 0, fails = 0;
  int m_ptr, m_words, m_done_at;
  bit m_err, m_ended;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wdata), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Reference encoder built from field positions and the opcode/funct tables.
  function automatic logic [31:0] ref_enc(input req_t r, output bit legal);
    int fn_tab[16];
    int op_tab[11];
    logic [31:0] rs, rt, rd, sh;
    int c;
    fn_tab = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A,
               32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07, 32'h08};
    op_tab = '{32'h08, 32'h09, 32'h0C, 32'h0D, 32'h0E, 32'h23, 32'h2B, 32'h04, 32'h05, 32'h02, 32'h03};
    c = int'(r.code);
    rs = 32'(r.rs) << 21; rt = 32'(r.rt) << 16; rd = 32'(r.rd) << 11; sh = 32'(r.sh) << 6;
    legal = 1'b1;
    if (c <= 8 || (c >= 12 && c <= 14)) return rs | rt | rd | 32'(fn_tab[c]);
    if (c >= 9 && c <= 11)              return rt | rd | sh | 32'(fn_tab[c]);
    if (c == 15)                        return rs | 32'h8;
    if (c >= 16 && c <= 24)             return (32'(op_tab[c-16]) << 26) | rs | rt | 32'(r.imm);
    if (c == 25 || c == 26)             return (32'(op_tab[c-16]) << 26) | 32'(r.tgt);
    if (c == 27)                        return STOP;
    legal = 1'b0;
    return 32'h0;
  endfunction

  function automatic req_t mk(input int code, rs, rt, rd, sh, imm, tgt, input bit last);
    req_t r;
    r.code = 5'(code); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.sh = 5'(sh);
    r.imm = 16'(imm); r.tgt = 26'(tgt); r.last = last;
    return r;
  endfunction

  task automatic model_restart();
    m_ptr = BASE; m_err = 0; m_ended = 0; m_words = 0; m_done_at = 0;
  endtask

  task automatic model_accept(input req_t r, input int c, input bit use_exp, input logic [31:0] exp_w);
    bit legal;
    logic [31:0] w;
    w = ref_enc(r, legal);
    if (use_exp) w = exp_w;
    if (legal) begin
      exp_q.push_back('{m_ptr, w, c + 1});
      m_ptr++;
    end else m_err = 1;
    if (r.last || (legal && m_ptr == LAST)) begin
      if (!r.last) m_err = 1;
      exp_q.push_back('{m_ptr, STOP, c + 2});
      m_words = m_ptr - BASE + 1;
      m_done_at = c + 3;
      m_ended = 1;
    end
  endtask

  task automatic send(input req_t r, input bit use_exp, input logic [31:0] exp_w);
    int c;
    @(negedge clk);
    in_valid = 1; in_code = r.code; in_rs = r.rs; in_rt = r.rt; in_rd = r.rd;
    in_shamt = r.sh; in_imm = r.imm; in_target = r.tgt; in_last = r.last;
    #1;
    c = cyc;
    if (in_ready) model_accept(r, c, use_exp, exp_w);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1; in_valid = 0;
    @(negedge clk);
    start = 0;
    model_restart();
  endtask

  task automatic finish_session();
    int k;
    idle();
    for (k = 0; k < 20 && !done; k++) @(negedge clk);
    check("done", 64'(done), 64'd1);
    check("done_cycle", 64'(cyc), 64'(m_done_at));
    check("count", 64'(count), 64'(m_words));
    check("err", 64'(err), 64'(m_err));
    check("busy_after", 64'(busy), 64'd0);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    req_t r;
    int n;
    rst_n = 0; start = 0; in_valid = 0; in_code = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_shamt = 0; in_imm = 0; in_target = 0; in_last = 0;
    model_restart();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'(BASE));
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    rst_n = 1;

    // Single ADD then STOP.
    do_start();
    send(mk(0, 8, 9, 10, 0, 0, 0, 1), 1, 32'h0109_5020);
    finish_session();
    send(mk(0, 1, 2, 3, 0, 0, 0, 1), 0, 0);
    check("ready_in_done", 64'(in_ready), 64'd0);

    // Back-to-back mixed formats with hand-computed words.
    do_start();
    send(mk(21, 29, 8, 0, 0, 16'h0004, 0, 0), 1, 32'h8FA8_0004);
    send(mk(9, 31, 9, 8, 2, 0, 0, 0), 1, 32'h0009_4080);
    send(mk(26, 0, 0, 0, 0, 0, 26'h10, 0), 1, 32'h0C00_0010);
    send(mk(24, 1, 2, 0, 0, 16'hFFFF, 0, 1), 1, 32'h1422_FFFF);
    finish_session();

    // Capacity overflow: DEPTH-1 words then forced STOP.
    do_start();
    for (int i = 0; i < DEPTH - 1; i++) send(mk(1, i, i + 1, i + 2, 0, 0, 0, 0), 0, 0);
    send(mk(0, 3, 4, 5, 0, 0, 0, 0), 0, 0);
    check("ready_when_full", 64'(in_ready), 64'd0);
    finish_session();

    // Illegal code mid-stream leaves the address unchanged.
    do_start();
    send(mk(0, 1, 2, 3, 0, 0, 0, 0), 0, 0);
    send(mk(30, 1, 2, 3, 0, 0, 0, 0), 0, 0);
    send(mk(16, 4, 5, 0, 0, 16'h1234, 0, 1), 0, 0);
    finish_session();

    // start overrides a same-cycle request.
    do_start();
    send(mk(2, 7, 7, 7, 0, 0, 0, 0), 0, 0);
    @(negedge clk);
    start = 1; in_valid = 1; in_last = 1; in_code = 5'd3;
    #1;
    check("ready_during_start", 64'(in_ready), 64'd0);
    @(negedge clk);
    start = 0; in_valid = 0;
    model_restart();
    check("restart_addr", 64'(imem_addr), 64'(BASE));
    check("restart_count", 64'(count), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    send(mk(5, 1, 1, 1, 0, 0, 0, 1), 0, 0);
    finish_session();

    // Asynchronous reset while a write is on the port.
    do_start();
    send(mk(4, 2, 3, 4, 0, 0, 0, 0), 0, 0);
    @(posedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("arst_we", 64'(imem_we), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    #1;
    check("arst_ready", 64'(in_ready), 64'd0);
    check("arst_count", 64'(count), 64'd0);

    // Random sessions, some overflowing, with idle gaps.
    for (int s = 0; s < 20; s++) begin
      do_start();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n && !m_ended; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        r = mk(($urandom_range(0, 9) == 0) ? 28 + $urandom_range(0, 3) : $urandom_range(0, 27),
               $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, i == n - 1);
        send(r, 0, 0);
      end
      finish_session();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
